// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - counter mode encodings and sequencer state type
package counter_pkg;

  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DOWN = 2'b01;
  localparam logic [1:0] MODO_UP3  = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FINISH
  } seq_state_t;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - saturating event counter with synchronous clear
module wrap_counter #(
  parameter int WRAP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [WRAP_W-1:0] count
);

  // Clear wins over increment so an accept in the same cycle starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - command sequencer for the 4-bit up/down counter; WRAP_COUNT_EN enables the RCO wrap counter
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 4
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_DIR,
  input  logic [WIDTH-1:0]  CMD_START,
  input  logic [WIDTH-1:0]  CMD_STOP,
  output logic              BUSY,
  output logic              DONE,
  output logic              ENB,
  output logic [1:0]        MODO,
  output logic [WIDTH-1:0]  D,
  input  logic [WIDTH-1:0]  Q,
  input  logic              RCO,
  output logic [WRAP_W-1:0] WRAPS
);

  seq_state_t       state;
  logic [WIDTH-1:0] start_r;
  logic [WIDTH-1:0] stop_r;
  logic             dir_r;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic [1:0]       modo_r;
  logic             accept;
  logic             at_stop;

  assign accept  = CMD_VALID && ready_r;
  assign at_stop = (Q == stop_r);

  // Outputs are registered alongside the state so they change with it.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state   <= IDLE;
      start_r <= '0;
      stop_r  <= '0;
      dir_r   <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      modo_r  <= MODO_UP;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            start_r <= CMD_START;
            stop_r  <= CMD_STOP;
            dir_r   <= CMD_DIR;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            modo_r  <= MODO_LOAD;
            state   <= LOAD;
          end
        end
        LOAD: begin
          modo_r <= dir_r ? MODO_DOWN : MODO_UP;
          state  <= RUN;
        end
        RUN: begin
          if (at_stop) begin
            done_r <= 1'b1;
            modo_r <= MODO_UP;
            state  <= FINISH;
          end
        end
        FINISH: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign CMD_READY = ready_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign MODO      = modo_r;
  assign D         = start_r;

  // Enable drops in the same cycle Q reaches stop, so the counter never overshoots.
  assign ENB = (state == LOAD) || ((state == RUN) && !at_stop);

`ifdef WRAP_COUNT_EN
  logic wrap_inc;
  assign wrap_inc = (state == RUN) && ENB && RCO;

  wrap_counter #(
    .WRAP_W(WRAP_W)
  ) u_wrap (
    .clk  (CLK),
    .rst_n(RESET_L),
    .clr  (accept),
    .inc  (wrap_inc),
    .count(WRAPS)
  );
`else
  logic unused_rco;
  assign unused_rco = RCO;
  assign WRAPS      = '0;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - self-checking bench for counter_sequencer with a counter register model
module tb_counter_sequencer;

  logic       CLK = 1'b0;
  logic       RESET_L;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic       CMD_DIR;
  logic [3:0] CMD_START;
  logic [3:0] CMD_STOP;
  logic       BUSY;
  logic       DONE;
  logic       ENB;
  logic [1:0] MODO;
  logic [3:0] D;
  logic [3:0] q = 4'd0;
  logic       rco;
  logic [3:0] WRAPS;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  counter_sequencer #(.WIDTH(4), .WRAP_W(4)) dut (
    .CLK      (CLK),
    .RESET_L  (RESET_L),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_DIR  (CMD_DIR),
    .CMD_START(CMD_START),
    .CMD_STOP (CMD_STOP),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ENB      (ENB),
    .MODO     (MODO),
    .D        (D),
    .Q        (q),
    .RCO      (rco),
    .WRAPS    (WRAPS)
  );

  // Counter register: not reset by the sequencer's reset.
  always @(posedge CLK) begin
    if (ENB) begin
      case (MODO)
        2'b00:   q <= q + 4'd1;
        2'b01:   q <= q - 4'd1;
        2'b10:   q <= q + 4'd3;
        default: q <= D;
      endcase
    end
  end
  assign rco = ENB && (((MODO == 2'b00) && (q == 4'd15)) || ((MODO == 2'b01) && (q == 4'd0)));

  task automatic issue(input logic [3:0] s, input logic [3:0] e, input logic dr);
    int t = 0;
    while (CMD_READY !== 1'b1 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    checks++;
    if (CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready_timeout observed=%b expected=1", CMD_READY);
    end
    CMD_START = s;
    CMD_STOP  = e;
    CMD_DIR   = dr;
    CMD_VALID = 1'b1;
    @(posedge CLK);
  endtask

  // Follows one accepted command from cycle 1 to cycle n+4; optionally offers the next one during BUSY.
  task automatic watch(input logic [3:0] s, input logic [3:0] e, input logic dr, input bit hold,
                       input logic [3:0] s2, input logic [3:0] e2, input logic d2);
    int n, exp_w, enb_cnt, done_cnt, done_cyc, busy_bad, ready_bad, modo_bad;
    n = dr ? ((int'(s) - int'(e) + 16) % 16) : ((int'(e) - int'(s) + 16) % 16);
`ifdef WRAP_COUNT_EN
    exp_w = dr ? int'(n > int'(s)) : int'(int'(s) + n > 15);
`else
    exp_w = 0;
`endif
    enb_cnt = 0; done_cnt = 0; done_cyc = 0; busy_bad = 0; ready_bad = 0; modo_bad = 0;
    for (int c = 1; c <= n + 4; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        CMD_VALID = hold;
        CMD_START = s2;
        CMD_STOP  = e2;
        CMD_DIR   = d2;
        checks++;
        if (MODO !== 2'b11 || D !== s || ENB !== 1'b1) begin
          errors++;
          $display("FAIL load_cycle observed modo=%b d=%0d enb=%b expected modo=11 d=%0d enb=1", MODO, D, ENB, s);
        end
      end
      if (c >= 2 && c <= n + 2) begin
        if (ENB === 1'b1) enb_cnt++;
        if (MODO !== {1'b0, dr}) modo_bad++;
      end
      if (MODO === 2'b10) modo_bad++;
      if (DONE === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c <= n + 3) begin
        if (BUSY !== 1'b1) busy_bad++;
        if (CMD_READY !== 1'b0) ready_bad++;
      end
      if (c == n + 3) begin
        checks++;
        if (q !== e) begin
          errors++;
          $display("FAIL final_q observed=%0d expected=%0d", q, e);
        end
      end
    end
    checks++;
    if (enb_cnt != n) begin
      errors++;
      $display("FAIL run_steps observed=%0d expected=%0d (start=%0d stop=%0d dir=%b)", enb_cnt, n, s, e, dr);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != n + 3) begin
      errors++;
      $display("FAIL done_cycle observed pulses=%0d cycle=%0d expected pulses=1 cycle=%0d", done_cnt, done_cyc, n + 3);
    end
    checks++;
    if (modo_bad != 0) begin
      errors++;
      $display("FAIL run_modo observed_bad=%0d expected=0", modo_bad);
    end
    checks++;
    if (busy_bad != 0 || ready_bad != 0) begin
      errors++;
      $display("FAIL busy_ready observed busy_bad=%0d ready_bad=%0d expected 0 0", busy_bad, ready_bad);
    end
    checks++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL ready_again observed ready=%b busy=%b expected 1 0", CMD_READY, BUSY);
    end
    checks++;
    if (WRAPS !== 4'(exp_w)) begin
      errors++;
      $display("FAIL wraps observed=%0d expected=%0d", WRAPS, exp_w);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 || ENB !== 1'b0 ||
        MODO !== 2'b00 || D !== 4'd0 || WRAPS !== 4'd0) begin
      errors++;
      $display("FAIL reset_values observed rdy=%b busy=%b done=%b enb=%b modo=%b d=%0d wraps=%0d expected 1 0 0 0 00 0 0",
               CMD_READY, BUSY, DONE, ENB, MODO, D, WRAPS);
    end
  endtask

  task automatic test_up();
    issue(4'd3, 4'd7, 1'b0);
    watch(4'd3, 4'd7, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_wrap();
    issue(4'd14, 4'd2, 1'b0);
    watch(4'd14, 4'd2, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    issue(4'd2, 4'd14, 1'b1);
    watch(4'd2, 4'd14, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_equal();
    issue(4'd9, 4'd9, 1'b0);
    watch(4'd9, 4'd9, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    issue(4'd5, 4'd1, 1'b1);
    watch(4'd5, 4'd1, 1'b1, 1'b1, 4'd12, 4'd3, 1'b0);
    @(posedge CLK);
    watch(4'd12, 4'd3, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int done_seen = 0;
    issue(4'd0, 4'd15, 1'b0);
    CMD_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    #2 RESET_L = 1'b0;
    #1;
    test_reset();
    repeat (3) begin
      @(negedge CLK);
      if (DONE === 1'b1 || BUSY === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL reset_hold observed_active=%0d expected=0", done_seen);
    end
    RESET_L = 1'b1;
    @(negedge CLK);
    issue(4'd6, 4'd11, 1'b0);
    watch(4'd6, 4'd11, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] s, e;
    logic       dr;
    for (int i = 0; i < 10; i++) begin
      s  = 4'($urandom_range(0, 15));
      e  = 4'($urandom_range(0, 15));
      dr = 1'($urandom_range(0, 1));
      issue(s, e, dr);
      watch(s, e, dr, 1'b0, 4'd0, 4'd0, 1'b0);
    end
  endtask

  initial begin
    RESET_L   = 1'b0;
    CMD_VALID = 1'b0;
    CMD_DIR   = 1'b0;
    CMD_START = 4'd0;
    CMD_STOP  = 4'd0;
    repeat (2) @(negedge CLK);
    test_reset();
    RESET_L = 1'b1;
    @(negedge CLK);
    test_up();
    test_wrap();
    test_equal();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
